// File: rtl/cod_binario_seq.sv
// Sequential binary encoder: accepts an N-bit request vector and emits the index of each set bit, one per handshake.
// Define COD_LSB_FIRST_EN for lowest-set-bit-first order; the default order is highest set bit first.
module cod_binario_seq #(
   parameter int N = 16,
   parameter int W = $clog2(N)   // derived from N; do not override
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_idx_q;
   logic         out_last_q, out_valid_q, busy_q, in_ready_q;

   function automatic logic [W-1:0] prio_idx(input logic [N-1:0] vec);
      prio_idx = '0;
`ifdef COD_LSB_FIRST_EN
      for (int i = N-1; i >= 0; i--) if (vec[i]) prio_idx = W'(i);
`else
      for (int i = 0; i < N; i++) if (vec[i]) prio_idx = W'(i);
`endif
   endfunction

   function automatic logic single_bit(input logic [N-1:0] vec);
      return (vec != '0) && ((vec & (vec - ONE)) == '0);
   endfunction

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (in_valid && (in_vec != '0)) begin
               pending_d = in_vec;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               pending_d = pending_q & ~(ONE << out_idx_q);
               if (out_last_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next pending vector and registered, so they
   // track pending one-for-one and never see in_vec combinationally.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         out_valid_q <= (state_d == SCAN);
         busy_q      <= (state_d == SCAN);
         in_ready_q  <= (state_d == IDLE);
         out_idx_q   <= (state_d == SCAN) ? prio_idx(pending_d) : '0;
         out_last_q  <= (state_d == SCAN) && single_bit(pending_d);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_cod_binario_seq.sv
// Self-checking bench for cod_binario_seq: directed boundary cases, then random traffic against a queue-based model.
module tb_cod_binario_seq;
   localparam int N = 16;
   localparam int W = 4;
`ifdef COD_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [N-1:0] in_vec;
   logic [W-1:0] out_idx;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: whether a vector is being drained, and the indices still to emit, in order.
   bit m_scan = 1'b0;
   int m_q[$];

   cod_binario_seq #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_edge();
      int idx;
      if (rst) begin
         m_q.delete();
         m_scan = 1'b0;
      end else if (!m_scan) begin
         if (in_valid && in_vec != '0) begin
            for (int k = 0; k < N; k++) begin
               idx = LSB ? k : N-1-k;
               if (in_vec[idx]) m_q.push_back(idx);
            end
            m_scan = 1'b1;
         end
      end else if (out_ready) begin
         void'(m_q.pop_front());
         if (m_q.size() == 0) m_scan = 1'b0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".valid"}, out_valid, m_scan);
      check({tag, ".busy"},  busy,      m_scan);
      check({tag, ".ready"}, in_ready,  !m_scan);
      check({tag, ".idx"},   out_idx,   m_scan ? m_q[0] : 0);
      check({tag, ".last"},  out_last,  m_scan && m_q.size() == 1);
   endtask

   task automatic step(input logic r, input logic iv, input logic [N-1:0] v,
                       input logic ordy, input string tag);
      rst = r; in_valid = iv; in_vec = v; out_ready = ordy;
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;

      step(1, 0, '0, 1, "rst0");
      step(1, 0, '0, 1, "rst1");
      check("rst_idx", out_idx, 0);
      check("rst_ready", in_ready, 1);
      step(0, 0, '0, 1, "idle");

      // Two-bit vector, no backpressure.
      step(0, 1, 16'h2008, 1, "v2008_acc");
      check("v2008_beat1", out_idx, LSB ? 3 : 13);
      check("v2008_last1", out_last, 0);
      step(0, 0, '0, 1, "v2008_b2");
      check("v2008_beat2", out_idx, LSB ? 13 : 3);
      check("v2008_last2", out_last, 1);
      step(0, 0, '0, 1, "v2008_done");
      check("v2008_ready", in_ready, 1);

      // Bit 0 alone is a real beat.
      step(0, 1, 16'h0001, 1, "v0001_acc");
      check("v0001_valid", out_valid, 1);
      check("v0001_last", out_last, 1);
      step(0, 0, '0, 1, "v0001_done");

      // Empty vector is consumed silently.
      step(0, 1, 16'h0000, 1, "v0000");
      check("v0000_valid", out_valid, 0);

      // Backpressure holds the beat; in_valid during SCAN is ignored.
      step(0, 1, 16'h0808, 0, "v0808_acc");
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 16'hFFFF, 0, "v0808_stall");
         check("v0808_hold", out_idx, 11);
      end
      step(0, 1, 16'hFFFF, 1, "v0808_b1");
      check("v0808_beat2", out_idx, 3);
      step(0, 0, '0, 1, "v0808_done");

      // Reset mid-SCAN discards the vector.
      step(0, 1, 16'hFFFF, 1, "vffff_acc");
      step(0, 0, '0, 1, "vffff_b1");
      step(0, 0, '0, 1, "vffff_b2");
      step(1, 0, '0, 1, "vffff_rst");
      check("vffff_rst_valid", out_valid, 0);
      step(0, 0, '0, 1, "vffff_idle");

      // Full drain of the all-ones vector.
      step(0, 1, 16'hFFFF, 1, "all_acc");
      for (int i = 0; i < N; i++) step(0, 0, '0, 1, "all_drain");
      check("all_idle", in_ready, 1);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [N-1:0] v;
         case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = 16'hFFFF;
            2:       v = ONEHOT($urandom_range(0, N-1));
            default: v = N'($urandom);
         endcase
         step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, v,
              $urandom_range(0, 3) != 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   function automatic logic [N-1:0] ONEHOT(input int b);
      logic [N-1:0] r;
      r = '0;
      r[b] = 1'b1;
      return r;
   endfunction

endmodule
